// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared state encoding, defaults and width helper for the bus mux
package bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } bus_state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_N_SRC = 24;

    // Ceiling log2 usable in constant expressions; at least 1 so a 2-source bus still has a select bit.
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_enc_n.sv
// rtl/prio_enc_n.sv - N-input priority encoder, highest set index wins
module prio_enc_n #(
    parameter int N     = 24,
    parameter int SEL_W = 5
) (
    input  logic [N-1:0]     req,
    output logic             any,
    output logic [SEL_W-1:0] sel
);

    always_comb begin
        any = 1'b0;
        sel = '0;
        // Ascending scan: later (higher) hits overwrite earlier ones.
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                any = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_mux_arb.sv
// rtl/bus_mux_arb.sv - registered priority bus multiplexer with contention detect and optional turnaround
module bus_mux_arb
    import bus_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int N_SRC      = DEF_N_SRC,
    parameter int CNT_W      = 8,
    parameter int TURNAROUND = 0,
    parameter int HOLD_LAST  = 0,
    localparam int SEL_W     = clog2(N_SRC)
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic [N_SRC-1:0]       src_en,
    input  logic [N_SRC*WIDTH-1:0] src_data,
    input  logic                   cnt_clr,
    output logic [WIDTH-1:0]       bus_out,
    output logic                   bus_valid,
    output logic [SEL_W-1:0]       bus_sel,
    output logic                   contention,
    output logic [CNT_W-1:0]       contention_cnt
);

    bus_state_t       state, state_n;
    logic             any;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] sel_data;
    logic             multi;
    logic [SEL_W-1:0] owner_n;
    logic [WIDTH-1:0] data_n;
    logic             valid_n;
    logic             seen;

    prio_enc_n #(
        .N     (N_SRC),
        .SEL_W (SEL_W)
    ) u_enc (
        .req (src_en),
        .any (any),
        .sel (sel)
    );

    assign sel_data = src_data[int'(sel)*WIDTH +: WIDTH];

    // Contention only needs a second set bit, not a full population count.
    always_comb begin
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_en[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        owner_n = bus_sel;
        valid_n = 1'b0;
        data_n  = (HOLD_LAST != 0) ? bus_out : '0;
        case (state)
            ST_IDLE, ST_TURN: begin
                if (any) begin
                    state_n = ST_DRIVE;
                    owner_n = sel;
                    valid_n = 1'b1;
                    data_n  = sel_data;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (!any) begin
                    state_n = ST_IDLE;
                end else if (sel == bus_sel || TURNAROUND == 0) begin
                    state_n = ST_DRIVE;
                    owner_n = sel;
                    valid_n = 1'b1;
                    data_n  = sel_data;
                end else begin
                    // Owner stays put through the idle gap; the new winner is re-picked on exit.
                    state_n = ST_TURN;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= ST_IDLE;
            bus_sel   <= '0;
            bus_out   <= '0;
            bus_valid <= 1'b0;
        end else begin
            state     <= state_n;
            bus_sel   <= owner_n;
            bus_out   <= data_n;
            bus_valid <= valid_n;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            contention     <= 1'b0;
            contention_cnt <= '0;
        end else begin
            contention <= multi;
            if (cnt_clr) begin
                contention_cnt <= multi ? CNT_W'(1) : '0;
            end else if (multi && contention_cnt != '1) begin
                contention_cnt <= contention_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bus_mux_arb.sv
// tb/tb_bus_mux_arb.sv - randomized self-checking bench over four bus configurations
module tb_bus_mux_arb;

    logic          clk;
    logic          clr_n;
    logic [63:0]   en_all;
    logic [2047:0] data_all;
    logic          cnt_clr;

    logic [31:0] bo [4];
    logic        bv [4];
    logic        cn [4];
    logic [7:0]  cc [4];
    logic [4:0]  s0, s1;
    logic [5:0]  s2;
    logic [0:0]  s3;

    int vectors;
    int miscompares;

    logic [31:0] m_data  [4];
    logic        m_valid [4];
    logic [6:0]  m_owner [4];
    logic        m_cont  [4];
    logic [7:0]  m_cnt   [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cfg0: 24 src no gap zero-fill; cfg1: 24 src gap hold; cfg2: 64 src gap zero-fill; cfg3: 2 src no gap hold
    bus_mux_arb #(.WIDTH(32), .N_SRC(24), .CNT_W(8), .TURNAROUND(0), .HOLD_LAST(0)) u0 (
        .clk(clk), .clr_n(clr_n), .src_en(en_all[23:0]), .src_data(data_all[24*32-1:0]),
        .cnt_clr(cnt_clr), .bus_out(bo[0]), .bus_valid(bv[0]), .bus_sel(s0),
        .contention(cn[0]), .contention_cnt(cc[0]));
    bus_mux_arb #(.WIDTH(32), .N_SRC(24), .CNT_W(8), .TURNAROUND(1), .HOLD_LAST(1)) u1 (
        .clk(clk), .clr_n(clr_n), .src_en(en_all[23:0]), .src_data(data_all[24*32-1:0]),
        .cnt_clr(cnt_clr), .bus_out(bo[1]), .bus_valid(bv[1]), .bus_sel(s1),
        .contention(cn[1]), .contention_cnt(cc[1]));
    bus_mux_arb #(.WIDTH(32), .N_SRC(64), .CNT_W(8), .TURNAROUND(1), .HOLD_LAST(0)) u2 (
        .clk(clk), .clr_n(clr_n), .src_en(en_all), .src_data(data_all),
        .cnt_clr(cnt_clr), .bus_out(bo[2]), .bus_valid(bv[2]), .bus_sel(s2),
        .contention(cn[2]), .contention_cnt(cc[2]));
    bus_mux_arb #(.WIDTH(32), .N_SRC(2), .CNT_W(8), .TURNAROUND(0), .HOLD_LAST(1)) u3 (
        .clk(clk), .clr_n(clr_n), .src_en(en_all[1:0]), .src_data(data_all[2*32-1:0]),
        .cnt_clr(cnt_clr), .bus_out(bo[3]), .bus_valid(bv[3]), .bus_sel(s3),
        .contention(cn[3]), .contention_cnt(cc[3]));

    function automatic int cfg_n(input int c);
        case (c)
            0, 1:    return 24;
            2:       return 64;
            default: return 2;
        endcase
    endfunction

    function automatic bit cfg_ta(input int c);
        return (c == 1 || c == 2);
    endfunction

    function automatic bit cfg_hl(input int c);
        return (c == 1 || c == 3);
    endfunction

    function automatic logic [6:0] osel(input int c);
        case (c)
            0:       return {2'b0, s0};
            1:       return {2'b0, s1};
            2:       return {1'b0, s2};
            default: return {6'b0, s3};
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_data[c] = '0; m_valid[c] = 1'b0; m_owner[c] = '0; m_cont[c] = 1'b0; m_cnt[c] = '0;
        end
    endtask

    // Reference rules: a visible source wins by highest index; a changed winner under
    // turnaround costs one invalid cycle, after which the bus is re-arbitrated from scratch.
    task automatic model_step();
        for (int c = 0; c < 4; c++) begin
            int n, pop, top;
            n = cfg_n(c);
            pop = 0;
            top = -1;
            for (int i = 0; i < n; i++) begin
                if (en_all[i]) begin
                    pop++;
                    top = i;
                end
            end
            if (top < 0 || (cfg_ta(c) && m_valid[c] && 7'(top) != m_owner[c])) begin
                m_valid[c] = 1'b0;
                if (!cfg_hl(c)) m_data[c] = '0;
            end else begin
                m_valid[c] = 1'b1;
                m_owner[c] = 7'(top);
                m_data[c]  = data_all[top*32 +: 32];
            end
            m_cont[c] = (pop > 1);
            if (cnt_clr)                     m_cnt[c] = (pop > 1) ? 8'd1 : 8'd0;
            else if (pop > 1 && m_cnt[c] < 255) m_cnt[c] = m_cnt[c] + 8'd1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_src(input int i, input logic [31:0] v);
        data_all[i*32 +: 32] = v;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < 64; i++) data_all[i*32 +: 32] = $urandom;
    endtask

    task automatic test_reset();
        clr_n = 1'b0; en_all = '0; cnt_clr = 1'b0; randomize_data();
        model_reset();
        #12;
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if ({bo[c], bv[c], osel(c), cn[c], cc[c]} !== {m_data[c], m_valid[c], m_owner[c], m_cont[c], m_cnt[c]}) begin
                miscompares++;
                $display("FAIL reset_hold cfg%0d: got %h %b %0d %b %0d want %h %b %0d %b %0d", c,
                         bo[c], bv[c], osel(c), cn[c], cc[c], m_data[c], m_valid[c], m_owner[c], m_cont[c], m_cnt[c]);
            end
        end
        @(negedge clk); clr_n = 1'b1;
        en_all = 64'h0000_0000_0010_0011;
        tick(); tick();
        // Asynchronous reset in the middle of a drive, checked before the next edge.
        #2 clr_n = 1'b0;
        model_reset();
        #1;
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if ({bo[c], bv[c], osel(c), cn[c], cc[c]} !== 49'd0) begin
                miscompares++;
                $display("FAIL reset_async cfg%0d: got %h %b %0d %b %0d want all zero", c,
                         bo[c], bv[c], osel(c), cn[c], cc[c]);
            end
        end
        #1 clr_n = 1'b1;
        en_all = '0;
        tick();
    endtask

    task automatic test_single();
        en_all = 64'd1 << 4;
        set_src(4, 32'hDEAD_BEEF);
        for (int k = 0; k < 2; k++) begin
            tick();
            for (int c = 0; c < 4; c++) begin
                vectors++;
                if ({bo[c], bv[c], osel(c), cn[c], cc[c]} !== {m_data[c], m_valid[c], m_owner[c], m_cont[c], m_cnt[c]}) begin
                    miscompares++;
                    $display("FAIL single cfg%0d: got %h %b %0d %b %0d want %h %b %0d %b %0d", c,
                             bo[c], bv[c], osel(c), cn[c], cc[c], m_data[c], m_valid[c], m_owner[c], m_cont[c], m_cnt[c]);
                end
            end
            vectors++;
            if ({bo[0], bv[0], s0} !== {(k == 0) ? 32'hDEAD_BEEF : 32'h1, 1'b1, 5'd4}) begin
                miscompares++;
                $display("FAIL single_abs step%0d: got %h %b %0d", k, bo[0], bv[0], s0);
            end
            set_src(4, 32'h1);
        end
    endtask

    task automatic test_contention();
        randomize_data();
        en_all = (64'd1 << 3) | (64'd1 << 20) | 64'd3;
        for (int k = 0; k < 300; k++) begin
            tick();
            for (int c = 0; c < 4; c++) begin
                vectors++;
                if ({bo[c], bv[c], osel(c), cn[c], cc[c]} !== {m_data[c], m_valid[c], m_owner[c], m_cont[c], m_cnt[c]}) begin
                    miscompares++;
                    $display("FAIL contention k%0d cfg%0d: got %h %b %0d %b %0d want %h %b %0d %b %0d", k, c,
                             bo[c], bv[c], osel(c), cn[c], cc[c], m_data[c], m_valid[c], m_owner[c], m_cont[c], m_cnt[c]);
                end
            end
        end
        vectors++;
        if ({s0, cn[0], cc[0], bo[0]} !== {5'd20, 1'b1, 8'd255, data_all[20*32 +: 32]}) begin
            miscompares++;
            $display("FAIL contention_sat: got sel=%0d cont=%b cnt=%0d data=%h want 20 1 255", s0, cn[0], cc[0], bo[0]);
        end
        en_all = 64'd1 << 20;
        tick();
        vectors++;
        if ({cn[0], cc[0]} !== {1'b0, 8'd255}) begin
            miscompares++;
            $display("FAIL contention_drop: got cont=%b cnt=%0d want 0 255", cn[0], cc[0]);
        end
    endtask

    task automatic test_cnt_clr();
        en_all = 64'h0000_0000_0000_0003;
        cnt_clr = 1'b1;
        tick();
        en_all = 64'd1 << 1;
        tick();
        cnt_clr = 1'b0;
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if ({bo[c], bv[c], osel(c), cn[c], cc[c]} !== {m_data[c], m_valid[c], m_owner[c], m_cont[c], m_cnt[c]}) begin
                miscompares++;
                $display("FAIL cnt_clr cfg%0d: got %h %b %0d %b %0d want %h %b %0d %b %0d", c,
                         bo[c], bv[c], osel(c), cn[c], cc[c], m_data[c], m_valid[c], m_owner[c], m_cont[c], m_cnt[c]);
            end
        end
        vectors++;
        if (cc[3] !== 8'd0) begin
            miscompares++;
            $display("FAIL cnt_clr_alone: got cnt=%0d want 0", cc[3]);
        end
    endtask

    task automatic test_turnaround();
        randomize_data();
        en_all = 64'd1 << 2;
        tick(); tick();
        en_all = 64'd1 << 7;
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int c = 0; c < 4; c++) begin
                vectors++;
                if ({bo[c], bv[c], osel(c), cn[c], cc[c]} !== {m_data[c], m_valid[c], m_owner[c], m_cont[c], m_cnt[c]}) begin
                    miscompares++;
                    $display("FAIL turnaround k%0d cfg%0d: got %h %b %0d %b %0d want %h %b %0d %b %0d", k, c,
                             bo[c], bv[c], osel(c), cn[c], cc[c], m_data[c], m_valid[c], m_owner[c], m_cont[c], m_cnt[c]);
                end
            end
            if (k == 0) begin
                vectors++;
                if ({bv[2], bo[2], s2, bv[0], s0} !== {1'b0, 32'd0, 6'd2, 1'b1, 5'd7}) begin
                    miscompares++;
                    $display("FAIL turnaround_gap: got v2=%b d2=%h s2=%0d v0=%b s0=%0d want 0 0 2 1 7",
                             bv[2], bo[2], s2, bv[0], s0);
                end
                // Winner changes during the gap: exit must pick the fresh one.
                en_all = 64'd1 << 9;
            end
        end
        vectors++;
        if ({bv[2], s2} !== {1'b1, 6'd9}) begin
            miscompares++;
            $display("FAIL turnaround_reeval: got v=%b sel=%0d want 1 9", bv[2], s2);
        end
    endtask

    task automatic test_release();
        logic [31:0] held;
        en_all = 64'd1 << 5;
        tick();
        held = bo[1];
        en_all = '0;
        tick();
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if ({bo[c], bv[c], osel(c), cn[c], cc[c]} !== {m_data[c], m_valid[c], m_owner[c], m_cont[c], m_cnt[c]}) begin
                miscompares++;
                $display("FAIL release cfg%0d: got %h %b %0d %b %0d want %h %b %0d %b %0d", c,
                         bo[c], bv[c], osel(c), cn[c], cc[c], m_data[c], m_valid[c], m_owner[c], m_cont[c], m_cnt[c]);
            end
        end
        vectors++;
        if ({bo[1], bv[1], bo[0], bv[0]} !== {held, 1'b0, 32'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL release_abs: got hold=%h v=%b zero=%h v=%b want %h 0 0 0", bo[1], bv[1], bo[0], bv[0], held);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            logic [63:0] e;
            e = '0;
            case ($urandom_range(0, 3))
                0: e = '0;
                1: e = 64'd1 << $urandom_range(0, 63);
                2: e = (64'd1 << $urandom_range(0, 63)) | (64'd1 << $urandom_range(0, 23));
                default: e = {$urandom, $urandom} & {$urandom, $urandom};
            endcase
            en_all = e;
            cnt_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) randomize_data();
            tick();
            for (int c = 0; c < 4; c++) begin
                vectors++;
                if ({bo[c], bv[c], osel(c), cn[c], cc[c]} !== {m_data[c], m_valid[c], m_owner[c], m_cont[c], m_cnt[c]}) begin
                    miscompares++;
                    $display("FAIL random k%0d cfg%0d: got %h %b %0d %b %0d want %h %b %0d %b %0d", k, c,
                             bo[c], bv[c], osel(c), cn[c], cc[c], m_data[c], m_valid[c], m_owner[c], m_cont[c], m_cnt[c]);
                end
            end
        end
        cnt_clr = 1'b0;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_contention();
        test_cnt_clr();
        test_turnaround();
        test_release();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
